cohort_dbg_capture: RTL
=======================

Name: cohort_dbg_capture

Overview:
- Parametrised successor to the Cohort debug-register bundle.
- Samples RegNum debug words of DataWidth bits into a Depth-entry snapshot ring whenever a trigger fires.
- Supports continuous (overwrite-oldest) and one-shot (stop-when-full) capture modes.
- Software or the debug unit reads any captured word through a valid/ready request/response port; sits between Cohort engine debug taps and the tile's MMIO/debug readout path.

Parameters:
- RegNum, 4: number of debug words per snapshot, >=1.
- DataWidth, 32: width of each debug word, >=1.
- Depth, 4: snapshot ring entries, power of two, >=2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- dbg_data_i  input  RegNum x DataWidth  live debug words, packed [RegNum-1:0][DataWidth-1:0]
- trig_i  input  1  capture request, one capture per cycle high
- mode_i  input  1  0 = continuous, 1 = one-shot
- clear_i  input  1  empty ring, clear sticky flags
- rd_req_valid_i  input  1  read request valid
- rd_req_ready_o  output  1  read request ready
- rd_req_idx_i  input  clog2(Depth)  entry index, 0 = oldest
- rd_req_reg_i  input  max(1,clog2(RegNum))  word index within entry
- rd_resp_valid_o  output  1  response valid
- rd_resp_ready_i  input  1  response ready
- rd_resp_data_o  output  DataWidth  read data
- rd_resp_err_o  output  1  index out of range
- count_o  output  clog2(Depth+1)  valid entries
- full_o  output  1  count_o == Depth
- overflow_o  output  1  sticky: continuous mode overwrote an entry
- drop_o  output  1  sticky: one-shot trigger ignored while full

Behaviour:
- Reset (async, rst_n low): count 0, wr/oldest pointers 0, overflow_o=0, drop_o=0, rd_resp_valid_o=0, rd_resp_data_o=0, rd_resp_err_o=0. Storage array not reset.
- Capture (trig_i=1 at rising edge, clear_i=0):
  - Writes all RegNum words of dbg_data_i into entry wr_ptr. Readable from the next cycle.
  - count<Depth: wr_ptr+1 mod Depth, count+1.
  - count==Depth, mode_i=0: overwrite oldest; wr_ptr and oldest both +1 mod Depth; count unchanged; overflow_o<=1.
  - count==Depth, mode_i=1: no write, no pointer change; drop_o<=1.
- mode_i is sampled per trigger; a change mid-operation affects only later triggers.
- clear_i=1: count, pointers, overflow_o, drop_o <= 0. Clear beats a same-cycle trig_i; that capture is silently discarded, no drop. An in-flight response is unaffected.
- Read handshake:
  - rd_req_ready_o = !rd_resp_valid_o || rd_resp_ready_i (combinational).
  - Request accepted on valid&&ready. Response registered and valid exactly 1 cycle later.
  - rd_resp_valid_o, data and err are held stable until rd_resp_ready_i. Back-to-back accepts give 1 response per cycle.
  - Physical entry = (oldest + rd_req_idx_i) mod Depth.
  - If rd_req_idx_i >= count or rd_req_reg_i >= RegNum: err=1, data=0. Otherwise err=0, data=stored word.
- Same-edge capture + read: the read resolves against pre-edge state (pointers, count, storage). A read of the entry being written returns the old contents or err.
- RegNum=1: rd_req_reg_i is 1 bit; value 1 gives err.

Decomposition:
- cohort_dbg_pkg: localparams for IdxW = clog2(Depth), RegW = max(1, clog2(RegNum)), CntW = clog2(Depth+1); typedef dbg_snap_t (RegNum x DataWidth packed); typedef dbg_rd_req_t {idx, reg}.
- Sub-module cohort_dbg_snap_ring: storage array, wr/oldest pointers, count, full/overflow/drop logic; exposes a combinational read port by (idx, reg).
- Top level: read handshake and response register only.

Test Plan:
- Reset, then 3 triggers with dbg_data_i word0 = 0x11, 0x22, 0x33 -> count_o=3; read idx0/reg0 -> 0x11, err=0; idx2 -> 0x33; idx3 -> err=1, data=0.
- Depth=4, mode 0, 6 triggers with word0 = 1..6 -> count_o=4, full_o=1, overflow_o=1; idx0 reads 3, idx3 reads 6.
- Depth=4, mode 1, 6 triggers with word0 = 1..6 -> idx0 reads 1, idx3 reads 4; drop_o=1, overflow_o=0.
- trig_i and clear_i high in the same cycle on a full ring -> count_o=0, flags 0, no entry written; next trigger lands at idx0.
- Request held with rd_resp_ready_i=0 for 3 cycles -> response stable, rd_req_ready_o=0; then ready=1 -> back-to-back reads of idx0..3 produce 4 responses on consecutive cycles.
- Assert rst_n low mid-response with count=2 -> rd_resp_valid_o drops immediately, count_o=0; first read after release of idx0 -> err=1.

Source files
------------

// File: rtl/cohort_dbg_pkg.sv
// Shared width helpers and default-configuration types for the Cohort debug capture block.
package cohort_dbg_pkg;

  localparam int unsigned DEF_REG_NUM    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 4;

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // A single-word snapshot still carries a 1-bit word select so that value 1 can flag an error.
  function automatic int unsigned reg_w(input int unsigned reg_num);
    return (reg_num > 1) ? $clog2(reg_num) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned IdxW = idx_w(DEF_DEPTH);
  localparam int unsigned RegW = reg_w(DEF_REG_NUM);
  localparam int unsigned CntW = cnt_w(DEF_DEPTH);

  typedef logic [DEF_REG_NUM-1:0][DEF_DATA_WIDTH-1:0] dbg_snap_t;

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic [RegW-1:0] sel;
  } dbg_rd_req_t;

endpackage

// File: rtl/cohort_dbg_capture_snap_ring.sv
// Snapshot ring: storage, write/oldest pointers, occupancy and sticky status flags,
// plus a combinational read port addressed relative to the oldest entry.
module cohort_dbg_snap_ring
  import cohort_dbg_pkg::*;
#(
  parameter int unsigned RegNum    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [RegNum-1:0][DataWidth-1:0]  wr_data_i,
  input  logic                              trig_i,
  input  logic                              mode_i,
  input  logic                              clear_i,
  input  logic [idx_w(Depth)-1:0]           rd_idx_i,
  input  logic [reg_w(RegNum)-1:0]          rd_reg_i,
  output logic [DataWidth-1:0]              rd_data_o,
  output logic                              rd_err_o,
  output logic [cnt_w(Depth)-1:0]           count_o,
  output logic                              full_o,
  output logic                              overflow_o,
  output logic                              drop_o
);

  localparam int unsigned IW = idx_w(Depth);
  localparam int unsigned RW = reg_w(RegNum);
  localparam int unsigned CW = cnt_w(Depth);
  localparam logic [CW-1:0] DepthC  = CW'(Depth);
  localparam logic [31:0]   RegNumC = 32'(RegNum);

  logic [RegNum-1:0][DataWidth-1:0] mem_q [Depth];

  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] old_ptr_q, old_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          drop_q, drop_d;
  logic          wr_en;
  logic          full_w;

  logic [IW-1:0] rd_phys;
  logic [RW-1:0] rd_sel;
  logic          idx_bad;
  logic          reg_bad;

  assign full_w = (count_q == DepthC);

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    old_ptr_d = old_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    wr_en     = 1'b0;
    if (clear_i) begin
      wr_ptr_d  = '0;
      old_ptr_d = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
      drop_d    = 1'b0;
    end else if (trig_i) begin
      if (!full_w) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end else if (!mode_i) begin
        wr_en     = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        old_ptr_d = old_ptr_q + 1'b1;
        ovf_d     = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      old_ptr_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      old_ptr_q <= old_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Out-of-range selects are steered to word 0 so the array is never indexed past its end.
  always_comb begin
    rd_phys   = old_ptr_q + rd_idx_i;
    idx_bad   = (CW'(rd_idx_i) >= count_q);
    reg_bad   = (32'(rd_reg_i) >= RegNumC);
    rd_sel    = reg_bad ? '0 : rd_reg_i;
    rd_err_o  = idx_bad || reg_bad;
    rd_data_o = rd_err_o ? '0 : mem_q[rd_phys][rd_sel];
  end

  assign count_o    = count_q;
  assign full_o     = full_w;
  assign overflow_o = ovf_q;
  assign drop_o     = drop_q;

endmodule

// File: rtl/cohort_dbg_capture.sv
// Cohort debug capture top: snapshot ring plus a registered valid/ready read-response port.
module cohort_dbg_capture
  import cohort_dbg_pkg::*;
#(
  parameter int unsigned RegNum    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [RegNum-1:0][DataWidth-1:0]  dbg_data_i,
  input  logic                              trig_i,
  input  logic                              mode_i,
  input  logic                              clear_i,
  input  logic                              rd_req_valid_i,
  output logic                              rd_req_ready_o,
  input  logic [idx_w(Depth)-1:0]           rd_req_idx_i,
  input  logic [reg_w(RegNum)-1:0]          rd_req_reg_i,
  output logic                              rd_resp_valid_o,
  input  logic                              rd_resp_ready_i,
  output logic [DataWidth-1:0]              rd_resp_data_o,
  output logic                              rd_resp_err_o,
  output logic [cnt_w(Depth)-1:0]           count_o,
  output logic                              full_o,
  output logic                              overflow_o,
  output logic                              drop_o
);

  localparam int unsigned IW = idx_w(Depth);
  localparam int unsigned RW = reg_w(RegNum);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [RW-1:0] sel;
  } rd_req_t;

  rd_req_t              req;
  logic [DataWidth-1:0] ring_data;
  logic                 ring_err;
  logic                 accept;

  logic                 resp_vld_q, resp_vld_d;
  logic                 resp_err_q, resp_err_d;
  logic [DataWidth-1:0] resp_data_q, resp_data_d;

  assign req = '{idx: rd_req_idx_i, sel: rd_req_reg_i};

  cohort_dbg_snap_ring #(
    .RegNum    (RegNum),
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  (dbg_data_i),
    .trig_i     (trig_i),
    .mode_i     (mode_i),
    .clear_i    (clear_i),
    .rd_idx_i   (req.idx),
    .rd_reg_i   (req.sel),
    .rd_data_o  (ring_data),
    .rd_err_o   (ring_err),
    .count_o    (count_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .drop_o     (drop_o)
  );

  assign rd_req_ready_o = !resp_vld_q || rd_resp_ready_i;

  // The ring read port reflects pre-edge state, so a same-edge capture never leaks into the response.
  always_comb begin
    accept      = rd_req_valid_i && rd_req_ready_o;
    resp_vld_d  = resp_vld_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    if (accept) begin
      resp_vld_d  = 1'b1;
      resp_err_d  = ring_err;
      resp_data_d = ring_data;
    end else if (rd_resp_ready_i) begin
      resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      resp_vld_q  <= resp_vld_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign rd_resp_valid_o = resp_vld_q;
  assign rd_resp_err_o   = resp_err_q;
  assign rd_resp_data_o  = resp_data_q;

endmodule
